// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and constants for the PLL lock supervisor.
//   pll_state_e : supervisor FSM state, fixed 3-bit encoding so debug taps
//                 and logic analyser captures decode the same way.
//   DEF_*       : default parameter values for pll_lock_supervisor.
//   clog2       : ceil(log2(n)), usable in constant expressions.
//   cnt_w       : width needed to hold 0..max_val, never less than 1.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PRST   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } pll_state_e;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_STABLE_CYC       = 1024;
    localparam int DEF_MAX_RETRY        = 4;
    localparam int DEF_SYNC_STAGES      = 2;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int max_val);
        int w;
        w = clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_sup_if.sv
// pll_sup_if: signals between the PLL lock supervisor, the PLL primitive
// and the downstream reset consumers.
//   pll_lock_async : PLL LOCK, asynchronous to the supervisor clock
//   pll_rst        : PLL RST, active-high
//   user_rst       : downstream video/DDR reset, active-high
//   ready          : high only while the supervisor is in RUN
//   fault          : sticky retry-exhausted flag
//   retry_cnt      : failed lock attempts since the last RUN or reset
//   state_dbg      : current supervisor state, for debug taps
//   lock_loss_cnt  : RUN->PRST lock-loss events, only present when
//                    PLL_LOCK_SUPERVISOR_LOSS_CNT_EN is defined
// Modports: master = supervisor side, slave = PLL / consumer side.
interface pll_sup_if
    import pll_sup_pkg::*;
#(
    parameter int MAX_RETRY = DEF_MAX_RETRY
);
    localparam int RETRY_W = cnt_w(MAX_RETRY);

    logic               pll_lock_async;
    logic               pll_rst;
    logic               user_rst;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    pll_state_e         state_dbg;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    logic [15:0]        lock_loss_cnt;

    modport master (
        input  pll_lock_async,
        output pll_rst, user_rst, ready, fault, retry_cnt, state_dbg,
        output lock_loss_cnt
    );
    modport slave (
        output pll_lock_async,
        input  pll_rst, user_rst, ready, fault, retry_cnt, state_dbg,
        input  lock_loss_cnt
    );
`else
    modport master (
        input  pll_lock_async,
        output pll_rst, user_rst, ready, fault, retry_cnt, state_dbg
    );
    modport slave (
        output pll_lock_async,
        input  pll_rst, user_rst, ready, fault, retry_cnt, state_dbg
    );
`endif
endinterface

// File: rtl/pll_lock_supervisor_sync_bit.sv
// sync_bit: multi-flop synchronizer for a single asynchronous status bit.
// All stages reset to 0, so a freshly reset design never sees a stale 1.
//   clk   : destination clock
//   rst   : synchronous active-high reset
//   d     : asynchronous input
//   q     : synchronized output, STAGES clocks of latency
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives PLL RST and the downstream reset from the
// synchronized PLL LOCK signal.
//   PRST   : PLL held in reset for RST_PULSE_CYC cycles
//   WAIT   : waiting up to LOCK_TIMEOUT_CYC cycles for lock; on timeout
//            either retry (PRST) or give up (FAULT) after MAX_RETRY retries
//   STABLE : lock must hold STABLE_CYC consecutive cycles; a dropout goes
//            back to WAIT without consuming a retry
//   RUN    : downstream released; lock loss restarts the PLL
//   FAULT  : sticky, left only through rst
// Ports: clk (free-running board clock), rst (synchronous, active-high),
//   bus (pll_sup_if.master: pll_lock_async in; pll_rst, user_rst, ready,
//   fault, retry_cnt, state_dbg out).
// Optional: define PLL_LOCK_SUPERVISOR_LOSS_CNT_EN to add bus.lock_loss_cnt,
//   a saturating 16-bit count of RUN->PRST transitions cleared only by rst.
// Every output is registered from the next state, so outputs change on the
// same edge as the state register.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
    input  logic      clk,
    input  logic      rst,
    pll_sup_if.master bus
);
    localparam int RETRY_W = cnt_w(MAX_RETRY);
    localparam int TMR_MAX = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC)
                           ? ((RST_PULSE_CYC > STABLE_CYC) ? RST_PULSE_CYC : STABLE_CYC)
                           : ((LOCK_TIMEOUT_CYC > STABLE_CYC) ? LOCK_TIMEOUT_CYC : STABLE_CYC);
    localparam int TMR_W   = cnt_w(TMR_MAX);

    localparam logic [TMR_W-1:0]   PULSE_LAST   = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]   STABLE_LAST  = TMR_W'(STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic               lock_s;
    pll_state_e         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               user_rst_q, user_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.pll_lock_async),
        .q   (lock_s)
    );

    // State register together with the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PRST;
            timer_q    <= '0;
            retry_q    <= '0;
            pll_rst_q  <= 1'b1;
            user_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            pll_rst_q  <= pll_rst_d;
            user_rst_q <= user_rst_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state logic. In WAIT the lock test comes first so a lock that
    // arrives on the timeout cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PRST: begin
                if (timer_q == PULSE_LAST) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = (retry_q == RETRY_LIMIT) ? ST_FAULT : ST_PRST;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) state_d = ST_PRST;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_PRST;
        endcase
    end

    // Output / datapath decode from the next state.
    always_comb begin
        pll_rst_d  = (state_d == ST_PRST);
        user_rst_d = (state_d != ST_RUN);
        ready_d    = (state_d == ST_RUN);
        fault_d    = (state_d == ST_FAULT);

        // The timer restarts on any transition and parks at all-ones in the
        // states that never look at it.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != {TMR_W{1'b1}}) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        // Only a WAIT timeout counts as a failed attempt; the FAULT branch
        // is taken at the limit, so the counter cannot pass MAX_RETRY.
        retry_d = retry_q;
        if (state_d == ST_RUN) begin
            retry_d = '0;
        end else if (state_q == ST_WAIT && state_d == ST_PRST) begin
            retry_d = retry_q + 1'b1;
        end
    end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    logic [15:0] loss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (state_q == ST_RUN && state_d == ST_PRST && loss_q != 16'hFFFF) begin
            loss_q <= loss_q + 16'd1;
        end
    end

    assign bus.lock_loss_cnt = loss_q;
`endif

    assign bus.pll_rst   = pll_rst_q;
    assign bus.user_rst  = user_rst_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_q;
    assign bus.state_dbg = state_q;
endmodule
